// File: rtl/game_reg_writer.sv
// Shadow register file for game display state, committed to an Avalon-MM byte
// register block once per frame. Only bytes touched since the last commit are sent.
module game_reg_writer #(
  parameter int MAX_BULLETS = 5,
  parameter int NREGS       = 8 + 4 * MAX_BULLETS
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   frame_tick,
  input  logic                   bg_we,
  input  logic [23:0]            bg_rgb,
  input  logic                   ship_we,
  input  logic [10:0]            ship_x,
  input  logic [9:0]             ship_y,
  input  logic                   bullet_we,
  input  logic [2:0]             bullet_idx,
  input  logic [10:0]            bullet_x,
  input  logic [9:0]             bullet_y,
  input  logic                   active_we,
  input  logic [MAX_BULLETS-1:0] bullet_active,
  output logic [4:0]             address,
  output logic [7:0]             writedata,
  output logic                   write,
  output logic                   chipselect,
  input  logic                   waitrequest,
  output logic                   busy,
  output logic                   done,
  output logic                   overrun,
  input  logic                   clr_overrun,
  output logic [1:0]             dbg_state
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SCAN  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam int         REG_ACT = 7 + 4 * MAX_BULLETS;

  // Handshake: a byte transfer completes on a rising edge where write=1 and
  // waitrequest=0; address/writedata are held unchanged until that edge.

  logic [1:0]       r_state;
  logic [7:0]       r_shadow [NREGS];
  logic [7:0]       r_buf    [NREGS];
  logic [NREGS-1:0] r_dirty;
  logic [NREGS-1:0] r_pend;
  logic [4:0]       r_addr;
  logic [7:0]       r_wdata;
  logic             r_write;
  logic             r_done;
  logic             r_overrun;

  logic [NREGS-1:0] w_we_mask;
  logic             w_snap;
  logic             w_found;
  logic [4:0]       w_idx;
  logic [7:0]       w_data;

  assign w_snap = (r_state == S_IDLE) && frame_tick;

  always_comb begin
    w_we_mask = '0;
    if (bg_we)   w_we_mask[2:0] = 3'b111;
    if (ship_we) w_we_mask[6:3] = 4'hF;
    for (int b = 0; b < MAX_BULLETS; b++) begin
      if (bullet_we && int'(bullet_idx) == b) w_we_mask[7+4*b +: 4] = 4'hF;
    end
    if (active_we) w_we_mask[REG_ACT] = 1'b1;
  end

  // Lowest pending index wins because the loop runs downward.
  always_comb begin
    w_found = 1'b0;
    w_idx   = 5'd0;
    w_data  = 8'd0;
    for (int i = NREGS - 1; i >= 0; i--) begin
      if (r_pend[i]) begin
        w_found = 1'b1;
        w_idx   = i[4:0];
        w_data  = r_buf[i];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREGS; i++) r_shadow[i] <= 8'h00;
      r_shadow[2] <= 8'h20;
      r_shadow[3] <= 8'hC8;
      r_shadow[5] <= 8'hF0;
    end else begin
      if (bg_we) begin
        r_shadow[0] <= bg_rgb[23:16];
        r_shadow[1] <= bg_rgb[15:8];
        r_shadow[2] <= bg_rgb[7:0];
      end
      if (ship_we) begin
        r_shadow[3] <= ship_x[7:0];
        r_shadow[4] <= {5'b0, ship_x[10:8]};
        r_shadow[5] <= ship_y[7:0];
        r_shadow[6] <= {6'b0, ship_y[9:8]};
      end
      for (int b = 0; b < MAX_BULLETS; b++) begin
        if (bullet_we && int'(bullet_idx) == b) begin
          r_shadow[7+4*b]  <= bullet_x[7:0];
          r_shadow[8+4*b]  <= {5'b0, bullet_x[10:8]};
          r_shadow[9+4*b]  <= bullet_y[7:0];
          r_shadow[10+4*b] <= {6'b0, bullet_y[9:8]};
        end
      end
      if (active_we) r_shadow[REG_ACT] <= 8'(bullet_active);
    end
  end

  // The snapshot takes the pre-edge shadow, so same-cycle updates wait a frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREGS; i++) r_buf[i] <= 8'h00;
      r_dirty <= '1;
    end else begin
      if (w_snap) begin
        for (int i = 0; i < NREGS; i++) r_buf[i] <= r_shadow[i];
      end
      r_dirty <= (w_snap ? '0 : r_dirty) | w_we_mask;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_pend  <= '0;
      r_addr  <= 5'd0;
      r_wdata <= 8'd0;
      r_write <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (frame_tick) begin
            r_pend  <= r_dirty;
            r_state <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (!w_found) begin
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_addr  <= w_idx;
            r_wdata <= w_data;
            r_write <= 1'b1;
            r_state <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (!waitrequest) begin
            r_pend[r_addr] <= 1'b0;
            r_write        <= 1'b0;
            r_state        <= S_SCAN;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // A set in the same cycle as a clear wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                          r_overrun <= 1'b0;
    else if (frame_tick && r_state != S_IDLE) r_overrun <= 1'b1;
    else if (clr_overrun)                  r_overrun <= 1'b0;
  end

  assign address    = r_addr;
  assign writedata  = r_wdata;
  assign write      = r_write;
  assign chipselect = r_write;
  assign busy       = (r_state != S_IDLE);
  assign done       = r_done;
  assign overrun    = r_overrun;
  assign dbg_state  = r_state;

endmodule

// File: doc/game_reg_writer.md
GAME_REG_WRITER -- requirements
Module: game_reg_writer

Interface
REQ-001 Parameter MAX_BULLETS, default 5, number of bullet slots.
REQ-002 Parameter NREGS, default 8+4*MAX_BULLETS (28), number of display byte registers.
REQ-003 clk  input  1  single system clock; all state changes on rising edge.
REQ-004 reset_n  input  1  one clock; reset is asynchronous and active-low.
REQ-005 frame_tick  input  1  one-cycle pulse at start of vertical blank; requests a commit.
REQ-006 bg_we  input  1  load bg_rgb into shadow; bg_rgb  input  24  {R,G,B}.
REQ-007 ship_we  input  1  load ship position; ship_x  input  11; ship_y  input  10.
REQ-008 bullet_we  input  1  load one bullet; bullet_idx  input  3; bullet_x  input  11; bullet_y  input  10.
REQ-009 active_we  input  1  load bullet_active  input  MAX_BULLETS  active bitmap.
REQ-010 address  output  5  Avalon-MM master byte register index.
REQ-011 writedata  output  8  write data; write  output  1; chipselect  output  1.
REQ-012 waitrequest  input  1  slave stall; transfer accepted on a cycle with write=1 and waitrequest=0.
REQ-013 busy  output  1  commit in progress; done  output  1  one-cycle pulse at end of commit.
REQ-014 overrun  output  1  sticky; clr_overrun  input  1  clears it.

Function
REQ-015 Shadow map: 0/1/2 = bg R/G/B; 3 = ship_x[7:0]; 4 = {5'b0,ship_x[10:8]}; 5 = ship_y[7:0]; 6 = {6'b0,ship_y[9:8]}; bullet i at 7+4i..10+4i in same x-lo/x-hi/y-lo/y-hi order; 7+4*MAX_BULLETS = zero-padded active bitmap.
REQ-016 Each byte has a dirty bit; any *_we sets dirty on every byte it covers, whether or not the value changed.
REQ-017 bullet_we with bullet_idx >= MAX_BULLETS shall be ignored (no shadow or dirty change).
REQ-018 Simultaneous *_we on different objects in one cycle shall all be applied.
REQ-019 States: IDLE, SCAN, WRITE.
REQ-020 IDLE + frame_tick: copy shadow bytes into transfer buffer and dirty mask into pending mask, clear dirty, go SCAN, busy=1 from next cycle.
REQ-021 A *_we in the same cycle as the snapshot shall update shadow and set dirty but shall not be in the current commit.
REQ-022 SCAN: pending empty -> IDLE with done=1 for one cycle and busy=0; else register lowest pending index into address and its buffer byte into writedata, go WRITE.
REQ-023 WRITE: write=chipselect=1; address and writedata stable while waitrequest=1; on acceptance clear that pending bit, deassert write/chipselect next cycle, go SCAN.
REQ-024 Writes issue in strictly ascending address order, at most one per two cycles; first write asserted two cycles after frame_tick.
REQ-025 frame_tick when not IDLE shall be ignored and set overrun; clr_overrun clears it, set wins if both occur in one cycle.
REQ-026 Shadow updates during a commit never alter transfer-buffer data being written.
REQ-027 write and chipselect shall be 0 in IDLE and SCAN.

Reset
REQ-028 reset_n low asynchronously forces IDLE, write=chipselect=0, address=0, writedata=0, busy=0, done=0, overrun=0, pending=0.
REQ-029 Reset shadow: bg 00/00/20, ship_x=200, ship_y=240, all bullets 0, active 0; all NREGS dirty bits set, so first commit writes every register.
REQ-030 Reset mid-transfer abandons the transfer with no further write cycles.

Verification
REQ-031 Reset, frame_tick, waitrequest=0 -> 28 writes, addresses 0..27, data 00,00,20,C8,00,F0,00 then 00s; done pulse; busy low.
REQ-032 After idle commit, ship_we x=0x405 y=0x2BC, frame_tick -> exactly 4 writes: 3=05, 4=04, 5=BC, 6=02.
REQ-033 bullet_we idx=2 x=0x123 y=0x045 with waitrequest high 3 cycles on first write -> address 15/data 23 held 4 cycles, then 16=01, 17=45, 18=00.
REQ-034 frame_tick during commit -> no restart, overrun=1 until clr_overrun; bullet_we idx=6 -> no writes next commit.
REQ-035 bullet_we idx=0 mid-commit -> not written this commit; next frame_tick writes addresses 7..10 only.
REQ-036 reset_n low during WRITE with waitrequest=1 -> write=0 immediately; after release, frame_tick writes all 28 registers.
